// File: rtl/if_stage.sv
`timescale 1ns/1ps
// Instruction-fetch stage: owns the PC, runs a single-outstanding imem request/valid
// handshake, drives the IF/ID register, buffers one response caught by a stall, applies BZ redirects.
module if_stage #(
  parameter int unsigned     PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [5:0]      branch_offset_imm,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_rdata,
  input  logic            imem_valid,
  output logic [15:0]     if_id_instr,
  output logic [PC_W-1:0] if_id_pc,
  output logic            if_id_valid
);

  typedef enum logic [1:0] {ISSUE, WAIT, HOLD, DROP} state_t;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] branch_target;
  logic [PC_W-1:0] hold_pc;
  logic [15:0]     hold_instr;
  logic            in_flight;

  assign pc_inc        = pc + PC_W'(1);
  assign branch_target = if_id_pc + PC_W'(1)
                       + {{(PC_W-6){branch_offset_imm[5]}}, branch_offset_imm};

  // In ISSUE with imem_req high the request is on the bus this cycle, so memory owes a
  // response; in WAIT/DROP a response is still owed unless it is arriving right now.
  assign in_flight = ((state == ISSUE) && imem_req)
                   || (((state == WAIT) || (state == DROP)) && !imem_valid);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ISSUE;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      if_id_instr <= '0;
      if_id_pc    <= '0;
      if_id_valid <= 1'b0;
      hold_instr  <= '0;
      hold_pc     <= '0;
    end else begin
      imem_req <= 1'b0;
      if (branch_taken) begin
        // Redirect beats stall: flush IF/ID, drop the buffer, discard any response this cycle.
        pc          <= branch_target;
        if_id_instr <= '0;
        if_id_valid <= 1'b0;
        if (in_flight) begin
          state <= DROP;
        end else begin
          state     <= ISSUE;
          imem_req  <= 1'b1;
          imem_addr <= branch_target;
        end
      end else begin
        unique case (state)
          ISSUE: begin
            if (imem_req) begin
              state <= WAIT;
            end else begin
              imem_req  <= 1'b1;  // first request after reset; imem_addr already equals pc
              imem_addr <= pc;
            end
            if (!stall) begin
              if_id_instr <= '0;
              if_id_valid <= 1'b0;
            end
          end
          WAIT: begin
            if (imem_valid) begin
              pc <= pc_inc;
              if (stall) begin
                hold_instr <= imem_rdata;
                hold_pc    <= pc;
                state      <= HOLD;
              end else begin
                if_id_instr <= imem_rdata;
                if_id_pc    <= pc;
                if_id_valid <= 1'b1;
                state       <= ISSUE;
                imem_req    <= 1'b1;
                imem_addr   <= pc_inc;
              end
            end else if (!stall) begin
              if_id_instr <= '0;
              if_id_valid <= 1'b0;
            end
          end
          HOLD: begin
            if (!stall) begin
              if_id_instr <= hold_instr;
              if_id_pc    <= hold_pc;
              if_id_valid <= 1'b1;
              state       <= ISSUE;
              imem_req    <= 1'b1;
              imem_addr   <= pc;
            end
          end
          DROP: begin
            if (imem_valid) begin
              state     <= ISSUE;
              imem_req  <= 1'b1;
              imem_addr <= pc;
            end
            if (!stall) begin
              if_id_instr <= '0;
              if_id_valid <= 1'b0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
`timescale 1ns/1ps
// Bench for if_stage: directed scenarios plus a randomized run, all checked against an
// architectural model of the instruction stream that should reach IF/ID.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [5:0]  branch_offset_imm = '0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = '0;
  logic        imem_valid = 1'b0;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc;
  logic        if_id_valid;

  int          n_assert = 0;
  int          n_fail = 0;
  logic [15:0] mem [0:65535];
  int          lat_min = 1;
  int          lat_max = 1;
  int          pend = 0;
  logic [15:0] pend_addr = '0;
  logic [15:0] exp_pc = '0;
  logic        model_on = 1'b0;

  if_stage #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .branch_taken      (branch_taken),
    .branch_offset_imm (branch_offset_imm),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .imem_rdata        (imem_rdata),
    .imem_valid        (imem_valid),
    .if_id_instr       (if_id_instr),
    .if_id_pc          (if_id_pc),
    .if_id_valid       (if_id_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // Memory: sees a request at the negedge of its cycle, answers with valid after lat cycles.
  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      pend       = 0;
      imem_valid = 1'b0;
      imem_rdata = '0;
    end else begin
      imem_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          imem_valid = 1'b1;
          imem_rdata = mem[pend_addr];
        end
      end
      if (imem_req) begin
        chk("one_outstanding", ((pend > 0) || imem_valid), 0);
        pend      = $urandom_range(lat_max, lat_min);
        pend_addr = imem_addr;
      end
    end
  end

  // One clock; afterwards compare IF/ID with what the stream model says must be there.
  task automatic step();
    logic [15:0] p_instr, p_pc;
    logic        p_valid, p_stall, p_br;
    logic [5:0]  p_off;
    int          off;
    p_instr = if_id_instr;
    p_pc    = if_id_pc;
    p_valid = if_id_valid;
    p_stall = stall;
    p_br    = branch_taken;
    p_off   = branch_offset_imm;
    @(negedge clk);
    if (model_on) begin
      if (p_br) begin
        chk("flush_valid", if_id_valid, 0);
        chk("flush_instr", if_id_instr, 0);
        off    = $signed(p_off);
        exp_pc = 16'(int'(p_pc) + 1 + off);
      end else if (p_stall) begin
        chk("stall_hold", {if_id_valid, if_id_pc, if_id_instr}, {p_valid, p_pc, p_instr});
      end else if (if_id_valid) begin
        chk("seq_pc", if_id_pc, exp_pc);
        chk("seq_instr", if_id_instr, mem[exp_pc]);
        exp_pc = exp_pc + 16'd1;
      end else begin
        chk("bubble_instr", if_id_instr, 0);
      end
    end
  endtask

  task automatic reset_dut();
    model_on          = 1'b0;
    rst               = 1'b0;
    stall             = 1'b0;
    branch_taken      = 1'b0;
    branch_offset_imm = '0;
    lat_min           = 1;
    lat_max           = 1;
    repeat (2) @(negedge clk);
    chk("reset_state", {imem_req, imem_addr, if_id_instr, if_id_pc, if_id_valid}, 0);
    rst      = 1'b1;
    exp_pc   = 16'h0000;
    model_on = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20; i++) begin
      step();
      if (if_id_valid) return;
    end
    chk(tag, if_id_valid, 1);
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 12; i++) begin
      step();
      if (imem_req) return;
    end
    chk(tag, imem_req, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: observed time %0t, required finish before 1000000", $time);
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [15:0] t1_instr [5];
    logic [15:0] t1_pc [5];
    int          idle;
    logic        quiet;

    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1201; mem[1] = 16'h2242; mem[2] = 16'h3283; mem[3] = 16'h0000;
    t1_instr = '{16'h1201, 16'h0000, 16'h2242, 16'h0000, 16'h3283};
    t1_pc    = '{16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0002};

    // 1: reset, first request, steady-state sequence at L=1
    reset_dut();
    step();
    chk("t1_first_req", {imem_req, imem_addr}, {1'b1, 16'h0000});
    step();
    chk("t1_req_pulse", imem_req, 0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t1_instr", if_id_instr, t1_instr[k]);
      chk("t1_valid", if_id_valid, (k % 2 == 0));
      if (k % 2 == 0) chk("t1_pc", if_id_pc, t1_pc[k]);
    end

    // 2: stall three cycles while 2242 is in flight
    reset_dut();
    repeat (3) step();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t2_hold", {if_id_valid, if_id_instr, imem_req}, {1'b1, 16'h1201, 1'b0});
    end
    stall = 1'b0;
    step();
    chk("t2_release", {if_id_valid, if_id_instr, if_id_pc}, {1'b1, 16'h2242, 16'h0001});
    chk("t2_next_req", {imem_req, imem_addr}, {1'b1, 16'h0002});

    // 3: taken branch from pc 4 with offset -2 while addr 5 is in flight
    reset_dut();
    for (int i = 0; i < 40; i++) begin
      step();
      if (if_id_valid && if_id_pc == 16'h0004) break;
    end
    chk("t3_reach_pc4", {if_id_valid, if_id_pc}, {1'b1, 16'h0004});
    branch_taken = 1'b1; branch_offset_imm = 6'h3E;
    step();
    branch_taken = 1'b0;
    chk("t3_flush", {if_id_valid, if_id_instr, imem_req}, 0);
    step();
    chk("t3_target_req", {imem_req, imem_addr}, {1'b1, 16'h0003});
    repeat (2) step();
    chk("t3_target_deliv", {if_id_valid, if_id_pc}, {1'b1, 16'h0003});
    repeat (2) step();
    chk("t3_after", {if_id_valid, if_id_pc, if_id_instr}, {1'b1, 16'h0004, mem[4]});

    // 4: branch and stall together while an instruction sits in the buffer
    reset_dut();
    repeat (3) step();
    stall = 1'b1;
    repeat (2) step();
    branch_taken = 1'b1; branch_offset_imm = 6'h05;
    step();
    chk("t4_redirect", {imem_req, imem_addr, if_id_valid, if_id_instr}, {1'b1, 16'h0006, 1'b0, 16'h0000});
    branch_taken = 1'b0; stall = 1'b0;
    repeat (2) step();
    chk("t4_deliver", {if_id_valid, if_id_pc, if_id_instr}, {1'b1, 16'h0006, mem[6]});

    // 5: wrap at the top of the address space, sequential and via branch
    reset_dut();
    repeat (3) step();
    branch_taken = 1'b1; branch_offset_imm = 6'h3D;
    step();
    branch_taken = 1'b0;
    wait_valid("t5_wait_fffe");
    chk("t5_pc_fffe", if_id_pc, 16'hFFFE);
    wait_valid("t5_wait_ffff");
    chk("t5_pc_ffff", if_id_pc, 16'hFFFF);
    wait_valid("t5_wait_0000");
    chk("t5_seq_wrap", if_id_pc, 16'h0000);
    branch_taken = 1'b1; branch_offset_imm = 6'h3D;
    step();
    branch_taken = 1'b0;
    wait_valid("t5_wait_fffe2");
    chk("t5_pc_fffe2", if_id_pc, 16'hFFFE);
    branch_taken = 1'b1; branch_offset_imm = 6'h01;
    step();
    branch_taken = 1'b0;
    wait_req("t5_wait_req");
    chk("t5_branch_wrap_addr", imem_addr, 16'h0000);
    wait_valid("t5_wait_0");
    chk("t5_branch_wrap_pc", if_id_pc, 16'h0000);

    // 6: asynchronous reset while waiting on memory
    reset_dut();
    repeat (3) step();
    stall = 1'b1;
    step();
    #2;
    model_on = 1'b0;
    rst = 1'b0;
    #1;
    chk("t6_async_reset", {imem_req, imem_addr, if_id_instr, if_id_pc, if_id_valid}, 0);
    stall = 1'b0;
    @(negedge clk);
    rst = 1'b1; exp_pc = 16'h0000; model_on = 1'b1;
    step();
    chk("t6_first_req", {imem_req, imem_addr}, {1'b1, 16'h0000});
    repeat (2) step();
    chk("t6_first_instr", {if_id_valid, if_id_pc, if_id_instr}, {1'b1, 16'h0000, 16'h1201});

    // Randomized: stalls, branches, memory latency 1..4
    reset_dut();
    lat_min = 1; lat_max = 4;
    idle = 0;
    for (int c = 0; c < 3000; c++) begin
      stall             = ($urandom_range(3) == 0);
      branch_taken      = if_id_valid && ($urandom_range(7) == 0);
      branch_offset_imm = 6'($urandom);
      quiet             = !stall && !branch_taken;
      step();
      if (if_id_valid) idle = 0;
      else if (quiet) idle++;
      if (idle > 30) begin
        chk("rand_progress", idle, 30);
        break;
      end
    end
    stall = 1'b0; branch_taken = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
